// File: rtl/mem_read_sink_pkg.sv
// ---------------------------------------------------------------------------
// mem_read_sink_pkg
//   Shared widths, FSM state encodings and the request-queue entry type for
//   mem_read_sink. The state constants are also used by the testbench to
//   inspect the controller state.
// ---------------------------------------------------------------------------
package mem_read_sink_pkg;

    // Address-pipeline widths shared with the upstream pipeline stages.
    localparam int unsigned ADDRESS_WIDTH = 32;
    localparam int unsigned ID_WIDTH      = 4;

    // Read controller state encoding.
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // One queued beat: address plus tag, stored together in the FIFO.
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [ID_WIDTH-1:0]      id;
    } req_entry_t;

endpackage

// File: rtl/mem_read_sink_if.sv
// ---------------------------------------------------------------------------
// mem_read_sink_if
//   Bundles the three handshake ports of mem_read_sink:
//     upstream beat   : in_address, in_id, in_valid  -> out_stall
//     memory read     : mem_req, mem_addr -> mem_gnt, mem_rvalid, mem_rdata
//     response        : resp_valid, resp_id, resp_data -> resp_ready
//   slave  : the sink's view (consumes beats, drives memory requests and
//            responses)
//   master : the environment's view (pipeline, memory and response consumer)
// ---------------------------------------------------------------------------
interface mem_read_sink_if
    import mem_read_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);

    logic [ADDRESS_WIDTH-1:0] in_address;
    logic [ID_WIDTH-1:0]      in_id;
    logic                     in_valid;
    logic                     out_stall;

    logic                     mem_req;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic                     mem_gnt;
    logic                     mem_rvalid;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    logic                     resp_valid;
    logic [ID_WIDTH-1:0]      resp_id;
    logic [DATA_WIDTH-1:0]    resp_data;
    logic                     resp_ready;

    modport slave (
        input  in_address, in_id, in_valid,
        output out_stall,
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output resp_valid, resp_id, resp_data,
        input  resp_ready
    );

    modport master (
        output in_address, in_id, in_valid,
        input  out_stall,
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  resp_valid, resp_id, resp_data,
        output resp_ready
    );

endinterface

// File: rtl/mem_read_sink_sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock circular FIFO with extra-MSB pointers (wrap tracked on the
//   MSB so full and empty are distinguishable without a separate flag).
//   Head entry is presented combinationally on rdata_o.
//   Ports:
//     clk_i, rst_i      clock, synchronous active-high reset
//     push_i, wdata_i   write request and data (ignored when full)
//     pop_i             remove head entry (ignored when empty)
//     rdata_o           current head entry
//     full_o, empty_o   occupancy flags
//     count_o           number of stored entries (0..DEPTH)
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: entries are only visible between pointers.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mem_read_sink.sv
// ---------------------------------------------------------------------------
// mem_read_sink
//   Terminal consumer of the address pipeline. Queues (address, id) beats,
//   performs one external memory read at a time and returns (id, data)
//   responses in acceptance order.
//   Ports:
//     clk, reset     clock, synchronous active-high reset
//     sink           mem_read_sink_if.slave: upstream beat + out_stall,
//                    memory req/gnt/rvalid port, response valid/ready port
//     stall_cycles   saturating count of cycles with out_stall high
//     proto_err      sticky flag: mem_rvalid seen while not waiting for data
// ---------------------------------------------------------------------------
module mem_read_sink
    import mem_read_sink_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    mem_read_sink_if.slave             sink,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles,
    output logic                       proto_err
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Request queue
    req_entry_t        push_entry;
    req_entry_t        head_entry;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    // Controller state
    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ID_WIDTH-1:0]      cur_id_q, cur_id_d;
    logic [ID_WIDTH-1:0]      resp_id_q, resp_id_d;
    logic [DATA_WIDTH-1:0]    resp_data_q, resp_data_d;
    logic                     proto_err_q, proto_err_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic stall;

    // Stall comes from the registered occupancy only, so the upstream stage
    // never sees a combinational path from its own in_valid.
    assign stall      = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign push_entry = '{addr: sink.in_address, id: sink.in_id};
    assign fifo_push  = sink.in_valid && !fifo_full;

    sync_fifo #(
        .WIDTH ($bits(req_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_id_d    = cur_id_q;
        resp_id_d   = resp_id_q;
        resp_data_d = resp_data_q;
        fifo_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cur_addr_d = head_entry.addr;
                    cur_id_d   = head_entry.id;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (sink.mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sink.mem_rvalid) begin
                    resp_id_d   = cur_id_q;
                    resp_data_d = sink.mem_rdata;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                // Chain straight into the next request when one is queued,
                // skipping IDLE to keep back-to-back reads one cycle shorter.
                if (sink.resp_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        cur_addr_d = head_entry.addr;
                        cur_id_d   = head_entry.id;
                        state_d    = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data is only legal while waiting; anything else (including data
    // in the grant cycle or a late return after reset) is dropped and flagged.
    always_comb begin
        proto_err_d = proto_err_q | (sink.mem_rvalid && (state_q != ST_WAIT));
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            cur_id_q    <= '0;
            resp_id_q   <= '0;
            resp_data_q <= '0;
            proto_err_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_id_q    <= cur_id_d;
            resp_id_q   <= resp_id_d;
            resp_data_q <= resp_data_d;
            proto_err_q <= proto_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign sink.out_stall  = stall;
    assign sink.mem_req    = (state_q == ST_REQ);
    assign sink.mem_addr   = cur_addr_q;
    assign sink.resp_valid = (state_q == ST_RESP);
    assign sink.resp_id    = resp_id_q;
    assign sink.resp_data  = resp_data_q;
    assign stall_cycles    = stall_cnt_q;
    assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_mem_read_sink.sv
// ---------------------------------------------------------------------------
// tb_mem_read_sink
//   Directed bench for mem_read_sink: a per-cycle vector table for the basic
//   read path and stray read data, then hand-written sequences for queue
//   fill/stall, grant hold, response backpressure and reset mid-transaction.
// ---------------------------------------------------------------------------
module tb_mem_read_sink;
    import mem_read_sink_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned SCW   = 16;
    localparam logic [31:0] MASK  = 32'hA5A5_0000;

    logic           clk;
    logic           reset;
    logic [SCW-1:0] stall_cycles;
    logic           proto_err;

    mem_read_sink_if #(.DATA_WIDTH(DW)) bus ();

    mem_read_sink #(
        .FIFO_DEPTH      (4),
        .DATA_WIDTH      (DW),
        .STALL_CNT_WIDTH (SCW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sink         (bus),
        .stall_cycles (stall_cycles),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Bench memory / response model state
    logic        gnt_en;
    logic        rv_en;
    logic        gpend;
    logic [31:0] gaddr;
    logic [3:0]  got_id[$];
    logic [31:0] got_data[$];

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic [3:0]  iid;
        logic        gnt;
        logic        rv;
        logic [31:0] rd;
        logic        rr;
        logic        es;
        logic        ereq;
        logic [31:0] eaddr;
        logic        erv;
        logic [3:0]  eid;
        logic [31:0] edata;
        logic        eperr;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic iv, input logic [31:0] ia, input logic [3:0] iid,
                                input logic gnt, input logic rv, input logic [31:0] rd,
                                input logic rr, input logic es, input logic ereq,
                                input logic [31:0] eaddr, input logic erv, input logic [3:0] eid,
                                input logic [31:0] edata, input logic eperr);
        vec_t v;
        v.iv = iv; v.ia = ia; v.iid = iid; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rr = rr;
        v.es = es; v.ereq = ereq; v.eaddr = eaddr; v.erv = erv; v.eid = eid;
        v.edata = edata; v.eperr = eperr;
        return v;
    endfunction

    function automatic logic [127:0] outs();
        return 128'({bus.out_stall, bus.mem_req, bus.mem_addr, bus.resp_valid,
                     bus.resp_id, bus.resp_data, proto_err});
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with the bench memory model and response scoreboard active.
    task automatic cycle();
        logic        g, rvd, hs;
        logic [31:0] ga, hd;
        logic [3:0]  hid;
        bus.mem_gnt    = gnt_en;
        bus.mem_rvalid = rv_en && gpend;
        bus.mem_rdata  = gaddr ^ MASK;
        g   = bus.mem_req && gnt_en;
        ga  = bus.mem_addr;
        rvd = bus.mem_rvalid;
        hs  = bus.resp_valid && bus.resp_ready;
        hid = bus.resp_id;
        hd  = bus.resp_data;
        tick();
        if (hs) begin
            got_id.push_back(hid);
            got_data.push_back(hd);
        end
        if (g) begin
            gpend = 1'b1;
            gaddr = ga;
        end else if (rvd) begin
            gpend = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.in_valid   = 1'b0;
        bus.in_address = '0;
        bus.in_id      = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.resp_ready = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        gpend = 1'b0;
        gaddr = '0;
        got_id.delete();
        got_data.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          first_stall;
        int          next_id;
        int          bad;
        logic        acc;

        gnt_en = 1'b0;
        rv_en  = 1'b1;
        gpend  = 1'b0;
        gaddr  = '0;
        reset  = 1'b1;
        tick();
        do_reset();

        // ---------------- reset state ----------------
        chk("reset_outputs", outs(), 128'd0);
        chk("reset_stall_cycles", 128'(stall_cycles), 128'd0);

        // ---------------- vector table ----------------
        //            iv    ia        iid    gnt   rv    rd              rr    es    req   addr      rv    id     data            perr
        tbl[0]  = mk(1'b1, 32'h10, 4'd3, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,         1'b0);
        tbl[1]  = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 4'd0, 32'h0,         1'b0);
        tbl[2]  = mk(1'b0, 32'h0,  4'd0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 4'd0, 32'h0,         1'b0);
        tbl[3]  = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 4'd0, 32'h0,         1'b0);
        tbl[4]  = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 4'd3, 32'hDEADBEEF,  1'b0);
        tbl[5]  = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 4'd3, 32'hDEADBEEF,  1'b0);
        tbl[6]  = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'h12345678,  1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 4'd3, 32'hDEADBEEF,  1'b0);
        tbl[7]  = mk(1'b1, 32'h20, 4'd5, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 4'd3, 32'hDEADBEEF,  1'b1);
        tbl[8]  = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h10, 1'b0, 4'd3, 32'hDEADBEEF,  1'b1);
        tbl[9]  = mk(1'b0, 32'h0,  4'd0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 4'd3, 32'hDEADBEEF,  1'b1);
        tbl[10] = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b1, 32'hCAFEF00D,  1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 4'd3, 32'hDEADBEEF,  1'b1);
        tbl[11] = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h20, 1'b1, 4'd5, 32'hCAFEF00D,  1'b1);
        tbl[12] = mk(1'b0, 32'h0,  4'd0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 4'd5, 32'hCAFEF00D,  1'b1);

        for (int i = 0; i < 13; i++) begin
            bus.in_valid   = tbl[i].iv;
            bus.in_address = tbl[i].ia;
            bus.in_id      = tbl[i].iid;
            bus.mem_gnt    = tbl[i].gnt;
            bus.mem_rvalid = tbl[i].rv;
            bus.mem_rdata  = tbl[i].rd;
            bus.resp_ready = tbl[i].rr;
            chk($sformatf("vec%0d", i), outs(),
                128'({tbl[i].es, tbl[i].ereq, tbl[i].eaddr, tbl[i].erv,
                      tbl[i].eid, tbl[i].edata, tbl[i].eperr}));
            tick();
        end

        // ---------------- fill / stall / grant hold ----------------
        do_reset();
        chk("perr_cleared_by_reset", 128'(proto_err), 128'd0);
        gnt_en      = 1'b0;
        rv_en       = 1'b1;
        next_id     = 0;
        first_stall = -1;
        bad         = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_stall && first_stall < 0) first_stall = c;
            if (c >= 2 && (!bus.mem_req || bus.mem_addr != 32'h100)) bad++;
            bus.in_valid   = (next_id <= 5);
            bus.in_id      = 4'(next_id);
            bus.in_address = 32'h100 + 32'(next_id);
            acc = bus.in_valid && !bus.out_stall;
            cycle();
            if (acc) next_id++;
        end
        chk("fill_first_stall_cycle", 128'(first_stall), 128'd5);
        chk("fill_accepted_beats", 128'(next_id), 128'd5);
        chk("grant_hold_req_addr", 128'(bad), 128'd0);
        chk("fill_stall_cycles", 128'(stall_cycles), 128'd5);

        gnt_en = 1'b1;
        for (int c = 0; c < 100 && got_id.size() < 6; c++) begin
            bus.in_valid   = (next_id <= 5);
            bus.in_id      = 4'(next_id);
            bus.in_address = 32'h100 + 32'(next_id);
            acc = bus.in_valid && !bus.out_stall;
            cycle();
            if (acc) next_id++;
        end
        bus.in_valid = 1'b0;
        chk("fill_resp_count", 128'(got_id.size()), 128'd6);
        for (int i = 0; i < got_id.size(); i++) begin
            chk($sformatf("fill_resp%0d_id", i), 128'(got_id[i]), 128'(i));
            chk($sformatf("fill_resp%0d_data", i), 128'(got_data[i]),
                128'((32'h100 + 32'(i)) ^ MASK));
        end

        // ---------------- response backpressure ----------------
        do_reset();
        gnt_en = 1'b1;
        rv_en  = 1'b1;
        bus.resp_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_id = 4'hA; bus.in_address = 32'h200;
        cycle();
        bus.in_id = 4'hB; bus.in_address = 32'h204;
        cycle();
        bus.in_valid = 1'b0;
        for (int c = 0; c < 20 && !bus.resp_valid; c++) cycle();
        chk("bp_resp_valid", 128'(bus.resp_valid), 128'd1);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!bus.resp_valid || bus.resp_id != 4'hA ||
                bus.resp_data != (32'h200 ^ MASK) || bus.mem_req) bad++;
            cycle();
        end
        chk("bp_held_stable", 128'(bad), 128'd0);
        bus.resp_ready = 1'b1;
        for (int c = 0; c < 30 && got_id.size() < 2; c++) cycle();
        chk("bp_resp_count", 128'(got_id.size()), 128'd2);
        if (got_id.size() == 2) begin
            chk("bp_first_id", 128'(got_id[0]), 128'hA);
            chk("bp_second_id", 128'(got_id[1]), 128'hB);
            chk("bp_second_data", 128'(got_data[1]), 128'(32'h204 ^ MASK));
        end

        // ---------------- reset mid-transaction ----------------
        do_reset();
        gnt_en = 1'b1;
        rv_en  = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid   = 1'b1;
            bus.in_id      = 4'(i);
            bus.in_address = 32'h300 + 32'(4 * i);
            cycle();
        end
        bus.in_valid = 1'b0;
        chk("midop_in_wait", 128'(dut.state_q), 128'(ST_WAIT));
        chk("midop_queued", 128'(dut.fifo_count), 128'd2);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("midop_reset_outputs", outs(), 128'd0);
        chk("midop_reset_stall_cycles", 128'(stall_cycles), 128'd0);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.mem_req || bus.out_stall) bad++;
            cycle();
        end
        chk("midop_fifo_empty", 128'(bad), 128'd0);
        rv_en = 1'b1;
        cycle();
        chk("late_rvalid_perr", 128'(proto_err), 128'd1);
        chk("late_rvalid_no_resp", 128'(bus.resp_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
